// File: rtl/adder_seq.sv
// Multi-cycle chunked ripple adder/subtractor.
// Operands latched on start; CHUNK bits summed per clock, LSB first.
module adder_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] psum_q;
  logic [WIDTH-1:0] psum_d;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic             co;
  logic             cmsb;
  logic             last;

  // One chunk of the ripple chain; cmsb recovers the carry into the top bit.
  always_comb begin
    idx    = IW'(int'(cnt_q) * CHUNK);
    ca     = a_q[idx +: CHUNK];
    cb     = b_q[idx +: CHUNK];
    {co, cs} = {1'b0, ca} + {1'b0, cb}
             + {{CHUNK{1'b0}}, c_q};
    cmsb   = cs[CHUNK-1] ^ ca[CHUNK-1]
           ^ cb[CHUNK-1];
    psum_d = psum_q;
    psum_d[idx +: CHUNK] = cs;
    last   = (cnt_q == LAST);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      psum_q <= '0;
      cnt_q  <= '0;
      sum    <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          a_q    <= a;
          b_q    <= sub ? ~b : b;
          c_q    <= sub ? ~cin : cin;
          psum_q <= '0;
          cnt_q  <= '0;
        end
      end else begin
        psum_q <= psum_d;
        c_q    <= co;
        cnt_q  <= cnt_q + 1'b1;
        if (last) begin
          cnt_q <= '0;
          sum   <= psum_d;
          carry <= co;
          ovf   <= cmsb ^ co;
          done  <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq: three configurations,
// directed corner cases and random operands against an arithmetic model.
module tb_adder_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic        cin;
  logic [31:0] a;
  logic [31:0] b;
  int          sel;

  logic [15:0] sum0;
  logic [7:0]  sum1;
  logic [31:0] sum2;
  logic [2:0]  carry_v, ovf_v, busy_v, done_v;
  logic [2:0]  st;

  logic [31:0] o_sum;
  logic        o_carry, o_ovf, o_busy, o_done;

  int errors = 0;
  int checks = 0;

  assign st[0] = start && (sel == 0);
  assign st[1] = start && (sel == 1);
  assign st[2] = start && (sel == 2);

  adder_seq #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sub),
    .a(a[15:0]), .b(b[15:0]), .cin(cin),
    .sum(sum0), .carry(carry_v[0]), .ovf(ovf_v[0]),
    .busy(busy_v[0]), .done(done_v[0])
  );

  adder_seq #(.WIDTH(8), .CHUNK(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sub),
    .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .sum(sum1), .carry(carry_v[1]), .ovf(ovf_v[1]),
    .busy(busy_v[1]), .done(done_v[1])
  );

  adder_seq #(.WIDTH(32), .CHUNK(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sub),
    .a(a), .b(b), .cin(cin),
    .sum(sum2), .carry(carry_v[2]), .ovf(ovf_v[2]),
    .busy(busy_v[2]), .done(done_v[2])
  );

  always_comb begin
    o_sum = 32'd0;
    case (sel)
      0:       o_sum = {16'd0, sum0};
      1:       o_sum = {24'd0, sum1};
      default: o_sum = sum2;
    endcase
    o_carry = carry_v[sel[1:0]];
    o_ovf   = ovf_v[sel[1:0]];
    o_busy  = busy_v[sel[1:0]];
    o_done  = done_v[sel[1:0]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int width_of(int s);
    return (s == 0) ? 16 : (s == 1) ? 8 : 32;
  endfunction

  function automatic int steps_of(int s);
    return (s == 0) ? 4 : (s == 1) ? 1 : 32;
  endfunction

  // Reference: plain integer arithmetic, {ovf, carry, sum}.
  function automatic logic [33:0] model(int w, bit s,
                                        logic [31:0] x,
                                        logic [31:0] y, bit c);
    longint ux, uy, mask, full, sx, sy, sr, half;
    bit     cy, ov;
    mask = (64'sd1 <<< w) - 1;
    ux   = longint'(x) & mask;
    uy   = longint'(y) & mask;
    half = 64'sd1 <<< (w - 1);
    sx   = (ux >= half) ? ux - (64'sd1 <<< w) : ux;
    sy   = (uy >= half) ? uy - (64'sd1 <<< w) : uy;
    if (s) begin
      full = ux - uy - longint'(c);
      cy   = (ux >= uy + longint'(c));
      sr   = sx - sy - longint'(c);
    end else begin
      full = ux + uy + longint'(c);
      cy   = (full > mask);
      sr   = sx + sy + longint'(c);
    end
    ov = (sr >= half) || (sr < -half);
    return {ov, cy, 32'(full & mask)};
  endfunction

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge after the start edge.
  task automatic launch(bit s, logic [31:0] x,
                        logic [31:0] y, bit c);
    sub   = s;
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done; junk=1 pulses start with noise while busy.
  task automatic finish(string tag, logic [31:0] es,
                        bit ec, bit eo, bit drop, bit junk);
    int lat = 0;
    int bc  = 0;
    while (!o_done && lat < 80) begin
      if (o_busy) bc++;
      if (junk && o_busy) begin
        a     = $urandom;
        b     = $urandom;
        sub   = 1'($urandom);
        cin   = 1'($urandom);
        start = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, ".lat"},   64'(lat), 64'(steps_of(sel)));
    check({tag, ".busyn"}, 64'(bc),  64'(steps_of(sel)));
    check({tag, ".busy"},  64'(o_busy),  64'd0);
    check({tag, ".sum"},   64'(o_sum),   64'(es));
    check({tag, ".carry"}, 64'(o_carry), 64'(ec));
    check({tag, ".ovf"},   64'(o_ovf),   64'(eo));
    if (drop) begin
      @(negedge clk);
      check({tag, ".drop"}, 64'(o_done), 64'd0);
    end
  endtask

  typedef struct {
    bit          s;
    logic [15:0] x;
    logic [15:0] y;
    bit          c;
    logic [15:0] es;
    bit          ec;
    bit          eo;
  } vec_t;

  vec_t vecs[8] = '{
    '{1'b0, 16'h000A, 16'h0005, 1'b0, 16'h000F, 1'b0, 1'b0},
    '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0},
    '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0},
    '{1'b1, 16'h0005, 16'h000A, 1'b0, 16'hFFFB, 1'b0, 1'b0},
    '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1},
    '{1'b1, 16'h1234, 16'h0234, 1'b1, 16'h0FFF, 1'b1, 1'b0}
  };

  initial begin
    logic [33:0] e;
    int          seen;
    sel   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.sum",   64'(o_sum),   64'd0);
    check("rst.carry", 64'(o_carry), 64'd0);
    check("rst.ovf",   64'(o_ovf),   64'd0);
    check("rst.busy",  64'(o_busy),  64'd0);
    check("rst.done",  64'(o_done),  64'd0);

    foreach (vecs[i]) begin
      launch(vecs[i].s, 32'(vecs[i].x), 32'(vecs[i].y), vecs[i].c);
      finish($sformatf("dir%0d", i), 32'(vecs[i].es),
             vecs[i].ec, vecs[i].eo, 1'b1, 1'b0);
    end

    // Start held with noise while busy must not disturb the result.
    launch(1'b0, 32'h1111, 32'h2222, 1'b1);
    finish("ignore", 32'h3334, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ignore.drop", 64'(o_done), 64'd1);

    // Start on the done cycle is accepted; previous result held.
    launch(1'b1, 32'h0100, 32'h0001, 1'b0);
    check("b2b.done", 64'(o_done), 64'd0);
    check("b2b.busy", 64'(o_busy), 64'd1);
    check("b2b.hold", 64'(o_sum),  64'h3334);
    finish("b2b", 32'h00FF, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset in the second run cycle clears everything, no done.
    launch(1'b0, 32'h4000, 32'h4000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst.sum",   64'(o_sum),   64'd0);
    check("mrst.carry", 64'(o_carry), 64'd0);
    check("mrst.busy",  64'(o_busy),  64'd0);
    check("mrst.done",  64'(o_done),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_done || o_busy) seen++;
    end
    check("mrst.quiet", 64'(seen), 64'd0);
    launch(1'b0, 32'h4000, 32'h4000, 1'b0);
    finish("mrst.next", 32'h8000, 1'b0, 1'b1, 1'b1, 1'b0);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
        logic [31:0] x, y;
        bit          sb, c;
        x  = $urandom;
        y  = $urandom;
        if (i % 5 == 0) y = x;
        sb = 1'($urandom);
        c  = 1'($urandom);
        e  = model(width_of(s), sb, x, y, c);
        launch(sb, x, y, c);
        finish($sformatf("rnd%0d.%0d", s, i), e[31:0],
               e[32], e[33], 1'b1, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
